// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO: default geometry and derived depth.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the FIFO.
// The master drives requests; the slave (the FIFO) returns data and status.
interface fifo_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH
) ();

  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] datain;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  full;
  logic                  empty;

  modport master (
    output w_en,
    output r_en,
    output datain,
    input  dataout,
    input  full,
    input  empty
  );

  modport slave (
    input  w_en,
    input  r_en,
    input  datain,
    output dataout,
    output full,
    output empty
  );

endinterface : fifo_if

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array.
// Synchronous write port, asynchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock FIFO: wrap-bit binary pointers, combinational flags from the
// registered pointers, and a registered read-data output.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic  wrclk,
  input  logic  wrst,
  fifo_if.slave bus
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dataout_q, dataout_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic                  mem_we_c;

  // Status flags: equal pointers mean empty; same address with opposite wrap bit means full.
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
              (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  end

  // Requests are judged independently against the pre-edge flags.
  always_comb begin
    wr_acc_c  = 1'b0;
    rd_acc_c  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dataout_d = dataout_q;
    mem_we_c  = 1'b0;

    wr_acc_c = bus.w_en && !full_c;
    rd_acc_c = bus.r_en && !empty_c;

    if (wr_acc_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      dataout_d = mem_rdata;
    end

    // Keep the array untouched while the block is held in reset.
    mem_we_c = wr_acc_c && wrst;
  end

  always_ff @(posedge wrclk or negedge wrst) begin
    if (!wrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dataout_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      dataout_q <= dataout_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (wrclk),
    .we    (mem_we_c),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (bus.datain),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.dataout = dataout_q;
  assign bus.full    = full_c;
  assign bus.empty   = empty_c;

endmodule : fifo

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed boundary steps plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic wrclk;
  logic wrst;

  fifo_if #(.DATA_WIDTH(DW)) bus ();

  fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (3)
  ) dut (
    .wrclk (wrclk),
    .wrst  (wrst),
    .bus   (bus)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  // Reference model: contents in arrival order plus last value read out.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  int            tests;
  int            fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dataout"}, 32'(bus.dataout), 32'(exp_dout));
    chk({tag, ".full"},    32'(bus.full),    32'(model_q.size() == DEPTH));
    chk({tag, ".empty"},   32'(bus.empty),   32'(model_q.size() == 0));
  endtask

  // One clock of traffic; the model decides acceptance from the pre-edge occupancy.
  task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    bit pre_full;
    bit pre_empty;
    pre_full    = (model_q.size() == DEPTH);
    pre_empty   = (model_q.size() == 0);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.datain  = d;
    @(posedge wrclk);
    #1;
    if (r && !pre_empty) exp_dout = model_q.pop_front();
    if (w && !pre_full)  model_q.push_back(d);
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    exp_dout   = '0;
    wrst       = 1'b0;
    bus.w_en   = 1'b0;
    bus.r_en   = 1'b0;
    bus.datain = '0;

    // Reset held for 10 clocks.
    repeat (10) @(posedge wrclk);
    #1;
    check_all("reset");

    // Requests during reset must be ignored.
    bus.w_en   = 1'b1;
    bus.r_en   = 1'b1;
    bus.datain = 8'hAA;
    repeat (2) @(posedge wrclk);
    #1;
    check_all("reset_req");
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    @(negedge wrclk);
    wrst = 1'b1;
    step("post_reset_idle", 1'b0, 1'b0, 8'h00);

    // Fill with 0x11..0x88, then an ignored 9th write.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 8'(i * 8'h11));
    chk("fill.full_flag", 32'(bus.full), 32'd1);
    step("fill.overflow", 1'b1, 1'b0, 8'h99);

    // Drain: 0x11..0x88, then an ignored 9th read.
    for (int i = 1; i <= 8; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00);
      chk("drain.value", 32'(bus.dataout), 32'(i * 8'h11));
    end
    step("drain.underflow", 1'b0, 1'b1, 8'h00);
    chk("drain.hold", 32'(bus.dataout), 32'h88);

    // Empty with both requests: write lands, dataout holds.
    step("empty_both", 1'b1, 1'b1, 8'h5A);
    chk("empty_both.hold", 32'(bus.dataout), 32'h88);
    step("empty_both.read", 1'b0, 1'b1, 8'h00);
    chk("empty_both.value", 32'(bus.dataout), 32'h5A);

    // Full with both requests: oldest read, new word dropped.
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'($urandom));
    step("full_both", 1'b1, 1'b1, 8'hEE);
    chk("full_both.full", 32'(bus.full), 32'd0);
    while (model_q.size() != 0) step("full_both.drain", 1'b0, 1'b1, 8'h00);

    // Alternating enables: 60 random words, enough to wrap the pointers repeatedly.
    for (int i = 0; i < 60; i++) begin
      step("alt.wr", 1'b1, 1'b0, 8'($urandom));
      step("alt.rd", 1'b0, 1'b1, 8'h00);
    end

    // Steady state at half full.
    for (int i = 0; i < 4; i++) step("half.fill", 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) step("half.both", 1'b1, 1'b1, 8'($urandom));
    chk("half.count_not_full", 32'(bus.full), 32'd0);

    // Random traffic across all occupancy levels.
    for (int i = 0; i < 400; i++) begin
      step("random", 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Asynchronous reset mid-stream takes effect without a clock edge.
    while (model_q.size() < 5) step("mid.fill", 1'b1, 1'b0, 8'($urandom));
    #2;
    wrst = 1'b0;
    #1;
    model_q.delete();
    exp_dout = '0;
    check_all("mid_reset");
    @(negedge wrclk);
    wrst = 1'b1;
    for (int i = 0; i < 30; i++) step("post_mid", 1'($urandom), 1'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fifo

// File: doc/fifo.md
# fifo

Single-clock first-in-first-out buffer of DATA_WIDTH-bit words with full/empty status flags. It decouples a producer and a consumer that share one clock domain. Writes and reads are enable-qualified on the same rising edge. The block is the storage element between a data source and a sink in the datapath.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 3, log2 of depth; depth = 2^ADDR_WIDTH (8 words)

Ports (one clock; reset is asynchronous and active-low):
- wrclk  input  1  sole clock; all state updates on rising edge
- wrst  input  1  asynchronous active-low reset; 0 clears the FIFO
- w_en  input  1  write request, sampled at rising edge
- r_en  input  1  read request, sampled at rising edge
- datain  input  DATA_WIDTH  write data, captured with an accepted write
- dataout  output  DATA_WIDTH  registered read data
- full  output  1  FIFO holds 2^ADDR_WIDTH words
- empty  output  1  FIFO holds 0 words

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide in binary. The low ADDR_WIDTH bits address memory; the MSB is a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) AND (low bits equal).
- Both flags are combinational from the registered pointers.
- Accepted write = w_en & ~full. On acceptance: mem[wr_ptr low] <= datain and wr_ptr += 1.
- Accepted read = r_en & ~empty. On acceptance: dataout <= mem[rd_ptr low] and rd_ptr += 1.
- Rejected requests are ignored with no side effects: no pointer change, no memory write, dataout holds.
- Write and read are evaluated independently against the pre-edge flags.
  - Full with w_en and r_en both high: only the read is accepted. The FIFO becomes depth-1.
  - Empty with both high: only the write is accepted.
  - Otherwise, simultaneous accepted read and write keep the count unchanged.
- Pointers wrap modulo 2^(ADDR_WIDTH+1). The address wraps modulo depth, transparently.
- Reset (wrst=0, asynchronous, at any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, dataout=0, so empty=1 and full=0.
  - Memory contents are not cleared and are don't-care.
- While wrst=0, all requests are ignored.
- Operation resumes at the first rising edge after wrst deasserts.

## Timing
- Write latency: a word written at edge N is readable at edge N+1. empty falls right after edge N.
- Read latency: dataout updates on the same edge that accepts the read, so the value is valid one edge after r_en is sampled high. It holds until the next accepted read.
- full rises right after the edge that accepts the 8th unread word. It falls right after the edge accepting a read.
- No combinational path exists from w_en/r_en/datain to any output.
- Reset assertion takes effect immediately, with no clock required.

## Structure
- Shared package fifo_pkg holds:
  - the default DATA_WIDTH and ADDR_WIDTH constants;
  - a localparam DEPTH = 1 << ADDR_WIDTH.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array.
  - Write port is synchronous: we, waddr, wdata.
  - Read port is asynchronous: raddr -> rdata.
  - It has no reset.
- The top level holds the pointers, flag logic and the dataout register.

## Test plan
- Reset: hold wrst=0 for 10 clocks with w_en=r_en=0 -> empty=1, full=0, dataout=0. Assert wrst=0 mid-stream -> flags return to empty=1, full=0 immediately.
- Fill: write 0x11..0x88 (8 words) on consecutive edges -> empty=0 after the first edge, full=1 after the 8th. A 9th write of 0x99 is ignored; subsequent reads return 0x11..0x88 only.
- Drain: from full, read 8 times -> dataout sequence 0x11,0x22,...,0x88, each valid one edge after its r_en. empty=1 after the 8th read; a 9th read leaves dataout=0x88 and pointers unchanged.
- Alternating enable: write every other cycle (w_en toggling) 60 random words while reading every other cycle -> read order equals write order, no loss or duplication, and the pointers wrap at least twice.
- Simultaneous at boundaries:
  - Full with w_en=r_en=1 -> oldest word read, new word dropped, full=0 afterwards.
  - Empty with both high -> write stored, dataout unchanged, empty=0 afterwards.
- Steady state: at half-full (4 words), w_en=r_en=1 for 20 cycles -> count stays 4, full=0, empty=0, and data order is preserved.
